ascii_arb: RTL and testbench

ASCII_ARB -- requirements
Module: ascii_arb

---
 rtl/ascii_arb.sv | 175 +++++++++++++++++
 tb/tb_ascii_arb.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ascii_arb.sv
// -----------------------------------------------------------------------------
// ascii_arb
//   Two-requester character arbiter feeding a single character buffer.
//   A requester that sends a non-terminator character takes a lock and keeps
//   the output until it sends LF (8'h0A) or ESC (8'h1B). If the lock holder
//   stays silent for p_timeout consecutive cycles, the lock is broken and an
//   LF is injected so the buffer sees a cleanly terminated line. When both
//   requesters want the idle arbiter, the priority pointer picks the winner.
//   The pointer moves to the other requester whenever a line ends.
//
// Parameters
//   p_timeout   idle cycles a lock may last before it is broken (2..1024)
//
// Ports
//   clk         clock; every register updates on the rising edge
//   rst         synchronous, active-high reset
//   req0_ascii  requester 0 character
//   req0_val    requester 0 character valid
//   req0_rdy    requester 0 accept (transfer when val and rdy are both high)
//   req1_ascii  requester 1 character
//   req1_val    requester 1 character valid
//   req1_rdy    requester 1 accept
//   ascii       merged character stream
//   ascii_val   one-cycle strobe qualifying ascii (no backpressure)
//   owner       one-hot lock holder: 01 = req0, 10 = req1, 00 = none
// -----------------------------------------------------------------------------
module ascii_arb #(
  parameter int p_timeout = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req0_ascii,
  input  logic       req0_val,
  output logic       req0_rdy,
  input  logic [7:0] req1_ascii,
  input  logic       req1_val,
  output logic       req1_rdy,
  output logic [7:0] ascii,
  output logic       ascii_val,
  output logic [1:0] owner
);

  localparam int                  lp_cnt_w    = $clog2(p_timeout);
  localparam logic [7:0]          lp_lf       = 8'h0A;
  localparam logic [7:0]          lp_esc      = 8'h1B;
  localparam logic [lp_cnt_w-1:0] lp_cnt_last = lp_cnt_w'(p_timeout - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOCK0,
    LOCK1,
    BREAK
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_ptr;        // 0 favours req0 on a tie, 1 favours req1
  logic                w_ptr_nxt;
  logic [lp_cnt_w-1:0] r_cnt;        // consecutive silent cycles in a lock
  logic [lp_cnt_w-1:0] w_cnt_nxt;
  logic [7:0]          r_ascii;
  logic                r_ascii_val;

  logic                w_xfer0;
  logic                w_xfer1;
  logic                w_xfer;
  logic [7:0]          w_char;
  logic                w_term;

  // Accept signals: decided from state, pointer and val only.
  always_comb begin
    // NOTE: every signal written in a combinational block gets a default
    // first; a path that skipped the assignment would infer a latch.
    req0_rdy = 1'b0;
    req1_rdy = 1'b0;
    if (!rst) begin
      case (r_state)
        IDLE: begin
          if (req0_val && (!req1_val || !r_ptr)) begin
            req0_rdy = 1'b1;
          end else if (req1_val) begin
            req1_rdy = 1'b1;
          end
        end
        LOCK0:   req0_rdy = 1'b1;
        LOCK1:   req1_rdy = 1'b1;
        default: ;
      endcase
    end
  end

  // At most one rdy is ever high, so the accepted character is unambiguous.
  assign w_xfer0 = req0_val & req0_rdy;
  assign w_xfer1 = req1_val & req1_rdy;
  assign w_xfer  = w_xfer0 | w_xfer1;
  assign w_char  = w_xfer1 ? req1_ascii : req0_ascii;
  assign w_term  = (w_char == lp_lf) || (w_char == lp_esc);

  // Next state, pointer and silence counter.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_xfer) begin
          if (w_term) begin
            // Line ended: the other requester gets the next tie.
            w_ptr_nxt = w_xfer0;
          end else begin
            w_state_nxt = w_xfer1 ? LOCK1 : LOCK0;
            w_cnt_nxt   = '0;
          end
        end
      end
      LOCK0, LOCK1: begin
        if (w_xfer) begin
          if (w_term) begin
            w_state_nxt = IDLE;
            w_ptr_nxt   = (r_state == LOCK0);
          end else begin
            w_cnt_nxt = '0;
          end
        end else if (r_cnt == lp_cnt_last) begin
          // Holder went silent too long; break before the counter could wrap.
          w_state_nxt = BREAK;
          w_ptr_nxt   = (r_state == LOCK0);
        end else begin
          w_cnt_nxt = r_cnt + lp_cnt_w'(1);
        end
      end
      BREAK:   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      r_state     <= IDLE;
      r_ptr       <= 1'b0;
      r_cnt       <= '0;
      r_ascii     <= 8'h00;
      r_ascii_val <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_xfer) begin
        r_ascii     <= w_char;
        r_ascii_val <= 1'b1;
      end else if (r_state == BREAK) begin
        // Terminate the abandoned line for the buffer.
        r_ascii     <= lp_lf;
        r_ascii_val <= 1'b1;
      end else begin
        r_ascii_val <= 1'b0;
      end
    end
  end

  always_comb begin
    owner = 2'b00;
    case (r_state)
      LOCK0:   owner = 2'b01;
      LOCK1:   owner = 2'b10;
      default: owner = 2'b00;
    endcase
  end

  assign ascii     = r_ascii;
  assign ascii_val = r_ascii_val;

endmodule

// File: tb/tb_ascii_arb.sv
// -----------------------------------------------------------------------------
// tb_ascii_arb
//   Bench for ascii_arb with a short lock timeout so lock breaks happen often.
//   A behavioural model (who holds the line, who is favoured, how long the
//   holder has been silent) predicts rdy, ascii, ascii_val and owner; a
//   scoreboard queue holds every character the model expects on the output.
//   A directed opening sequence pins the model with literal values, then
//   random traffic runs on both ports.
// -----------------------------------------------------------------------------
module tb_ascii_arb;

  localparam int         P   = 4;
  localparam logic [7:0] LF  = 8'h0A;
  localparam logic [7:0] ESC = 8'h1B;

  logic       clk;
  logic       rst;
  logic [7:0] req0_ascii;
  logic       req0_val;
  logic       req0_rdy;
  logic [7:0] req1_ascii;
  logic       req1_val;
  logic       req1_rdy;
  logic [7:0] ascii;
  logic       ascii_val;
  logic [1:0] owner;

  ascii_arb #(.p_timeout(P)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_ascii (req0_ascii),
    .req0_val   (req0_val),
    .req0_rdy   (req0_rdy),
    .req1_ascii (req1_ascii),
    .req1_val   (req1_val),
    .req1_rdy   (req1_rdy),
    .ascii      (ascii),
    .ascii_val  (ascii_val),
    .owner      (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  int         m_holder = -1;   // requester holding the line, -1 = nobody
  int         m_ptr    = 0;    // requester favoured on a tie
  int         m_silent = 0;    // cycles the holder has sent nothing
  bit         m_break  = 1'b0; // this cycle is the lock-break cycle
  bit         m_ready  = 1'b0;
  logic [7:0] m_ascii  = 8'h00;
  bit         m_val    = 1'b0;
  logic [7:0] sb_q[$];

  int         m_g;
  bit         m_v;
  logic [7:0] m_c;

  // Which requester may transfer this cycle (-1 = none).
  function automatic int grant();
    if (rst || m_break)        return -1;
    if (m_holder >= 0)         return m_holder;
    if (req0_val && req1_val)  return m_ptr;
    if (req0_val)              return 0;
    if (req1_val)              return 1;
    return -1;
  endfunction

  always @(posedge clk) begin
    m_g     = grant();
    m_ready = 1'b1;
    if (rst) begin
      m_holder = -1;
      m_ptr    = 0;
      m_silent = 0;
      m_break  = 1'b0;
      m_ascii  = 8'h00;
      m_val    = 1'b0;
      sb_q.delete();
    end else if (m_break) begin
      m_break = 1'b0;
      m_ascii = LF;
      m_val   = 1'b1;
      sb_q.push_back(LF);
    end else begin
      m_v = (m_g == 0) ? req0_val : (m_g == 1) ? req1_val : 1'b0;
      m_c = (m_g == 1) ? req1_ascii : req0_ascii;
      if (m_v) begin
        m_ascii = m_c;
        m_val   = 1'b1;
        sb_q.push_back(m_c);
        if (m_c == LF || m_c == ESC) begin
          m_holder = -1;
          m_ptr    = 1 - m_g;
        end else begin
          m_holder = m_g;
          m_silent = 0;
        end
      end else begin
        m_val = 1'b0;
        if (m_holder >= 0) begin
          if (m_silent == P - 1) begin
            m_break  = 1'b1;
            m_ptr    = 1 - m_holder;
            m_holder = -1;
          end else begin
            m_silent++;
          end
        end
      end
    end
  end

  // Compare process: every cycle, mid-period.
  logic [7:0] sb_exp;
  always @(negedge clk) begin
    if (m_ready) begin
      check("rdy0", {31'd0, req0_rdy}, {31'd0, grant() == 0});
      check("rdy1", {31'd0, req1_rdy}, {31'd0, grant() == 1});
      check("ascii_val", {31'd0, ascii_val}, {31'd0, m_val});
      check("ascii", {24'd0, ascii}, {24'd0, m_ascii});
      check("owner", {30'd0, owner},
            {30'd0, (m_holder == 0) ? 2'b01 : (m_holder == 1) ? 2'b10 : 2'b00});
      if (ascii_val === 1'b1) begin
        if (sb_q.size() > 0) begin
          sb_exp = sb_q.pop_front();
          check("sb_char", {24'd0, ascii}, {24'd0, sb_exp});
        end else begin
          check("sb_unexpected_strobe", {31'd0, ascii_val}, 32'd0);
        end
      end else if (sb_q.size() > 0) begin
        check("sb_missing_strobe", {31'd0, ascii_val}, 32'd1);
        sb_q.delete();
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  // Apply one cycle of inputs just after a rising edge, then wait to mid-cycle.
  task automatic step(input bit r, input bit v0, input logic [7:0] c0,
                      input bit v1, input logic [7:0] c1);
    @(posedge clk);
    #2;
    rst        = r;
    req0_val   = v0;
    req0_ascii = c0;
    req1_val   = v1;
    req1_ascii = c1;
    @(negedge clk);
  endtask

  function automatic logic [7:0] rand_char();
    int r;
    r = $urandom_range(0, 15);
    if (r == 0) return LF;
    if (r == 1) return ESC;
    if (r == 2) return 8'h7F;
    return 8'($urandom_range(0, 255));
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst        = 1'b1;
    req0_val   = 1'b0;
    req0_ascii = 8'h00;
    req1_val   = 1'b0;
    req1_ascii = 8'h00;

    // Reset: both rdy low even with val high; outputs cleared.
    step(1, 1, 8'h41, 1, 8'h42);
    check("rst_rdy0", {31'd0, req0_rdy}, 32'd0);
    check("rst_rdy1", {31'd0, req1_rdy}, 32'd0);
    step(1, 1, 8'h41, 1, 8'h42);
    check("reset_ascii_val", {31'd0, ascii_val}, 32'd0);
    check("reset_ascii", {24'd0, ascii}, 32'h00);
    check("reset_owner", {30'd0, owner}, 32'd0);

    // Tie after reset: req0 wins, 'A' locks req0.
    step(0, 1, 8'h41, 1, 8'h42);
    check("tie_rdy0", {31'd0, req0_rdy}, 32'd1);
    check("tie_rdy1", {31'd0, req1_rdy}, 32'd0);

    // req0 sends "hi\n" while req1 streams 'x'.
    step(0, 1, 8'h68, 1, 8'h78);
    check("first_ascii", {24'd0, ascii}, 32'h41);
    check("first_val", {31'd0, ascii_val}, 32'd1);
    check("first_owner", {30'd0, owner}, 32'h1);
    check("lock_rdy1", {31'd0, req1_rdy}, 32'd0);
    step(0, 1, 8'h69, 1, 8'h78);
    check("lock_h", {24'd0, ascii}, 32'h68);
    step(0, 1, LF, 1, 8'h78);
    check("lock_i", {24'd0, ascii}, 32'h69);
    step(0, 1, 8'h7A, 1, 8'h78);
    check("lock_lf", {24'd0, ascii}, 32'h0A);
    check("lock_lf_owner", {30'd0, owner}, 32'd0);
    check("rr_rdy1", {31'd0, req1_rdy}, 32'd1);
    check("rr_rdy0", {31'd0, req0_rdy}, 32'd0);

    // req1 now holds the line; reset in LOCK1.
    step(0, 0, 8'h00, 1, 8'h79);
    check("rr_ascii", {24'd0, ascii}, 32'h78);
    check("rr_owner", {30'd0, owner}, 32'h2);
    step(1, 0, 8'h00, 1, 8'h79);
    check("rst_lock_rdy1", {31'd0, req1_rdy}, 32'd0);
    check("lock1_y", {24'd0, ascii}, 32'h79);
    step(0, 1, 8'h51, 1, 8'h52);
    check("rst_lock_val", {31'd0, ascii_val}, 32'd0);
    check("rst_lock_owner", {30'd0, owner}, 32'd0);
    check("rst_tie_rdy0", {31'd0, req0_rdy}, 32'd1);

    // 'Q' locks req0, then four silent cycles lead to a break.
    step(0, 0, 8'h00, 1, 8'h52);
    check("q_ascii", {24'd0, ascii}, 32'h51);
    check("q_owner", {30'd0, owner}, 32'h1);
    step(0, 0, 8'h00, 1, 8'h52);
    check("silent_val", {31'd0, ascii_val}, 32'd0);
    step(0, 0, 8'h00, 1, 8'h52);
    step(0, 0, 8'h00, 1, 8'h52);
    check("silent4_owner", {30'd0, owner}, 32'h1);
    step(0, 0, 8'h00, 1, 8'h52);
    check("brk_owner", {30'd0, owner}, 32'd0);
    check("brk_rdy0", {31'd0, req0_rdy}, 32'd0);
    check("brk_rdy1", {31'd0, req1_rdy}, 32'd0);

    // Injected LF; pointer favours req1, which sends ESC from IDLE.
    step(0, 1, 8'h53, 1, ESC);
    check("brk_lf_ascii", {24'd0, ascii}, 32'h0A);
    check("brk_lf_val", {31'd0, ascii_val}, 32'd1);
    check("ptr_req1_rdy1", {31'd0, req1_rdy}, 32'd1);
    check("ptr_req1_rdy0", {31'd0, req0_rdy}, 32'd0);
    step(0, 1, 8'h53, 1, 8'h52);
    check("esc_ascii", {24'd0, ascii}, 32'h1B);
    check("esc_owner", {30'd0, owner}, 32'd0);
    check("esc_ptr_rdy0", {31'd0, req0_rdy}, 32'd1);

    // 'S' locks req0, silence to BREAK, then reset during BREAK.
    step(0, 0, 8'h00, 0, 8'h00);
    check("s_ascii", {24'd0, ascii}, 32'h53);
    step(0, 0, 8'h00, 0, 8'h00);
    step(0, 0, 8'h00, 0, 8'h00);
    step(0, 0, 8'h00, 0, 8'h00);
    step(1, 0, 8'h00, 0, 8'h00);
    check("brk2_owner", {30'd0, owner}, 32'd0);
    step(0, 1, 8'h61, 1, 8'h62);
    check("rst_brk_no_lf", {31'd0, ascii_val}, 32'd0);
    check("rst_brk_rdy0", {31'd0, req0_rdy}, 32'd1);
    step(0, 0, 8'h00, 0, 8'h00);
    check("rst_brk_a", {24'd0, ascii}, 32'h61);

    // Random traffic on both ports.
    for (int i = 0; i < 10000; i++) begin
      step(($urandom_range(0, 199) == 0),
           1'($urandom_range(0, 1)), rand_char(),
           1'($urandom_range(0, 1)), rand_char());
    end

    // Drain: silence long enough for any lock to break and its LF to appear.
    for (int i = 0; i < 3 * P; i++) begin
      step(0, 0, 8'h00, 0, 8'h00);
    end
    check("sb_drained", sb_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
